x1_ioctl_loader: RTL and testbench
==================================

# x1_ioctl_loader

Parametrised download router between the HPS ioctl stream and the Sharp X1 core's on-chip memories (IPL, character generator, PCG, GRAM preload). It matches `ioctl_index` against a table of NREG regions and forwards bounds-checked writes to the matching region as one registered write strobe. On request it zero-fills the unwritten tail of the region. It holds the CPU in reset for the whole transfer and reports per-region completion and error status.

## Interface
Parameters:
- NREG, 4 — number of target regions (1..8).
- MAW, 16 — width of `mem_addr`; the largest region is 2**MAW bytes.
- REG_IDX, {8'h03,8'h02,8'h01,8'h00} — packed NREG×8 ioctl index per region; region i is bits [8i+7:8i].
- REG_AW, {5'd16,5'd13,5'd11,5'd13} — packed NREG×5 address width per region, each ≤ MAW; region size = 2**REG_AW[i].
- FILL_EN, NREG'b0 — bit i set: after the download ends, fill region i from the high-water mark to its end.
- FILL_BYTE, 8'h00 — value written during fill.

Ports:
- clk_sys in 1 — system clock; the only clock.
- reset in 1 — synchronous, active-high.
- ioctl_download in 1 — download active (level).
- ioctl_index in 8 — download target index.
- ioctl_wr in 1 — one-cycle data strobe.
- ioctl_addr in 25 — byte address within the download.
- ioctl_dout in 8 — data byte.
- mem_we out NREG — one-hot write strobe, bit i addresses region i.
- mem_addr out MAW — write address, zero-extended.
- mem_din out 8 — write data.
- cpu_hold out 1 — holds the CPU in reset while a transfer is in progress.
- busy out 1 — state ≠ IDLE.
- done out NREG — one-cycle pulse when region i completes.
- err out 1 — sticky error flag; cleared only by reset or by the start of a new matched download.

## Operation
- States: IDLE, LOAD, SKIP, FILL, DONE.
- IDLE:
  - With `ioctl_download` high, latch `ioctl_index`.
  - If the index matches a region, go to LOAD with `sel` = the lowest matching region. Clear `hwm`. Clear `err`.
  - If no region matches, go to SKIP.
- LOAD, on each `ioctl_wr`:
  - If `ioctl_addr` < 2**REG_AW[sel]: next cycle assert `mem_we[sel]`, with `mem_addr`=`ioctl_addr[MAW-1:0]` and `mem_din`=`ioctl_dout`. Update `hwm` = max(`hwm`, `ioctl_addr`+1).
  - Otherwise drop the write and set `err`.
- LOAD, on `ioctl_download` low: go to FILL if FILL_EN[sel] and `hwm` < size; otherwise go to DONE.
- SKIP: all `ioctl_wr` are ignored. Stay until `ioctl_download` goes low, then return to IDLE. No `done` pulse, `err` unchanged.
- FILL:
  - One write per cycle: `mem_we[sel]`=1, `mem_addr`=`hwm`, `mem_din`=FILL_BYTE, then `hwm`++.
  - After the write to address size−1, go to DONE.
  - Any `ioctl_wr` during FILL is dropped and sets `err`.
- DONE: pulse `done[sel]` for one cycle, then go to IDLE.
  - If `ioctl_download` is already high again, IDLE starts the new transfer on the following cycle.
- `cpu_hold` = 1 in LOAD, SKIP, FILL and DONE; 0 in IDLE.
- Width rules:
  - `hwm` is MAW+1 bits, so a full 2**MAW region is representable.
  - The address compare uses all 25 bits of `ioctl_addr`.
  - `mem_addr` bits above REG_AW[sel] are 0.

## Timing
- Reset values: all outputs are 0, state = IDLE, `hwm` = 0, `sel` = 0.
- Reset asserted mid-LOAD or mid-FILL aborts in the same clock. No `done` pulse; `mem_we` is 0 on the next cycle.
- Latencies:
  - `ioctl_download` rising → state LOAD and `cpu_hold`=1: 1 cycle.
  - `ioctl_wr` → `mem_we`: exactly 1 cycle.
  - `mem_addr` and `mem_din` are registered with `mem_we` and stay valid only during the strobe cycle.
- Back-to-back `ioctl_wr` every cycle is supported at full rate with no drops.
- An `ioctl_wr` coincident with the `ioctl_download` falling edge is still accepted. The transition to FILL or DONE happens one cycle after its strobe.
- `ioctl_wr` and `ioctl_download` rising in the same cycle in IDLE: the write is dropped and does not set `err`.
- FILL length = size − `hwm` cycles. DONE lasts 1 cycle. `cpu_hold` falls on the cycle after DONE.
- At most one `mem_we` bit is high in any cycle.

## Test plan
- Region 0 (AW 13) loads 4096 sequential bytes 0x00..0xFF repeating → 4096 `mem_we[0]` strobes, each 1 cycle after `ioctl_wr`, with matching addr/data. Then a 1-cycle `done[0]` pulse, `err`=0, and `cpu_hold` low 2 cycles after download low.
- Region 1 (AW 11), FILL_EN[1]=1, loads 1000 bytes → 1048 fill writes of 0x00 at 0x3E8..0x7FF, then `done[1]`.
- Index 0x00 with a write at `ioctl_addr`=0x2000 → the write is dropped, `err`=1, and valid writes before and after are still forwarded.
- Index 0x7F (no match) with 16 writes → no `mem_we`, SKIP until download low, no `done`, `cpu_hold` high throughout.
- Reset asserted at byte 100 of a FILL_EN download → outputs all 0 next cycle, no `done`. A new download afterwards completes normally.
- Second download rising during FILL of the first → the first completes (`done` pulse), then the second enters LOAD 2 cycles after DONE. Writes during FILL set `err`; `err` is then cleared when the new download is matched.

Source files
------------

// File: rtl/x1_ioctl_loader.sv
// Routes the HPS ioctl download stream into one of NREG on-chip memory regions,
// optionally zero-filling the unwritten tail, while holding the CPU in reset.
module x1_ioctl_loader #(
  parameter int                 NREG      = 4,
  parameter int                 MAW       = 16,
  parameter logic [NREG*8-1:0]  REG_IDX   = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter logic [NREG*5-1:0]  REG_AW    = {5'd16, 5'd13, 5'd11, 5'd13},
  parameter logic [NREG-1:0]    FILL_EN   = '0,
  parameter logic [7:0]         FILL_BYTE = 8'h00
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic [NREG-1:0] mem_we,
  output logic [MAW-1:0]  mem_addr,
  output logic [7:0]      mem_din,
  output logic            cpu_hold,
  output logic            busy,
  output logic [NREG-1:0] done,
  output logic            err,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SKIP = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [MAW:0]    hwm_q, hwm_d;
  logic [NREG-1:0] mem_we_q, mem_we_d;
  logic [MAW-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic [NREG-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic [4:0]      aw_sel;
  logic [25:0]     size_sel;
  logic [NREG-1:0] sel_oh;
  logic            match;
  logic [2:0]      match_idx;
  logic            in_range;
  logic [MAW:0]    wr_end;
  logic [MAW:0]    hwm_wr;

  // Region decode: properties of the selected region and the lowest index match.
  always_comb begin
    aw_sel    = '0;
    sel_oh    = '0;
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_q == 3'(i)) begin
        aw_sel    = REG_AW[5*i +: 5];
        sel_oh[i] = 1'b1;
      end
    end
    for (int i = NREG - 1; i >= 0; i--) begin
      if (ioctl_index == REG_IDX[8*i +: 8]) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
    end
    size_sel = 26'(1) << aw_sel;
    in_range = {1'b0, ioctl_addr} < size_sel;
    wr_end   = ioctl_addr[MAW:0] + (MAW+1)'(1);
    hwm_wr   = (wr_end > hwm_q) ? wr_end : hwm_q;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    hwm_d      = hwm_q;
    mem_we_d   = '0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    done_d     = '0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download) begin
          if (match) begin
            state_d = ST_LOAD;
            sel_d   = match_idx;
            hwm_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = ST_SKIP;
          end
        end
      end
      ST_LOAD: begin
        if (ioctl_wr) begin
          if (in_range) begin
            mem_we_d   = sel_oh;
            mem_addr_d = ioctl_addr[MAW-1:0];
            mem_din_d  = ioctl_dout;
            hwm_d      = hwm_wr;
          end else begin
            err_d = 1'b1;
          end
        end
        // The fill decision sees hwm including a write coincident with download low.
        if (!ioctl_download) begin
          if (|(FILL_EN & sel_oh) && (26'(hwm_d) < size_sel)) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_DONE;
            done_d  = sel_oh;
          end
        end
      end
      ST_SKIP: begin
        if (!ioctl_download) state_d = ST_IDLE;
      end
      ST_FILL: begin
        mem_we_d   = sel_oh;
        mem_addr_d = hwm_q[MAW-1:0];
        mem_din_d  = FILL_BYTE;
        hwm_d      = hwm_q + (MAW+1)'(1);
        if (ioctl_wr) err_d = 1'b1;
        if (26'(hwm_d) == size_sel) begin
          state_d = ST_DONE;
          done_d  = sel_oh;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      hwm_q      <= '0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hwm_q      <= hwm_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_hold  = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_x1_ioctl_loader.sv
// Bench for x1_ioctl_loader: a vector table of whole downloads, hand-written
// corner sequences and random downloads, all scored against a transfer-level model.
`timescale 1ns/1ps
module tb_x1_ioctl_loader;

  localparam int         NREG      = 4;
  localparam int         MAW       = 16;
  localparam logic [3:0] FILL_EN   = 4'b0010;
  localparam logic [7:0] FILL_BYTE = 8'hE5;

  logic            clk_sys = 1'b0;
  logic            reset, ioctl_download, ioctl_wr;
  logic [7:0]      ioctl_index, ioctl_dout;
  logic [24:0]     ioctl_addr;
  logic [NREG-1:0] mem_we, done;
  logic [MAW-1:0]  mem_addr;
  logic [7:0]      mem_din;
  logic            cpu_hold, busy, err;
  logic [2:0]      dbg_state;

  x1_ioctl_loader #(
    .NREG(NREG), .MAW(MAW), .FILL_EN(FILL_EN), .FILL_BYTE(FILL_BYTE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  logic [31:0] cyc = '0;
  always @(posedge clk_sys) cyc <= cyc + 32'd1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [59:0] exp_q[$];
  logic [59:0] act_q[$];
  logic [35:0] dexp_q[$];
  logic [35:0] dact_q[$];
  int          last_nwe;
  logic [3:0]  last_done;

  always @(negedge clk_sys) begin
    if (mem_we != '0) begin
      act_q.push_back({cyc, mem_we, mem_addr, mem_din});
      n_chk++;
      if (!$onehot(mem_we)) begin
        n_fail++;
        $display("FAIL we_onehot: got %b required one bit set", mem_we);
      end
    end
    if (done != '0) dact_q.push_back({cyc, done});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [59:0] a, e;
    logic [35:0] da, de;
    last_nwe  = act_q.size();
    last_done = '0;
    foreach (dact_q[i]) last_done |= dact_q[i][3:0];
    chk({tag, "_nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s_wr: got cyc=%0d we=%b addr=%h din=%h required cyc=%0d we=%b addr=%h din=%h",
                 tag, a[59:28], a[27:24], a[23:8], a[7:0], e[59:28], e[27:24], e[23:8], e[7:0]);
        act_q.delete();
        exp_q.delete();
      end
    end
    chk({tag, "_ndone"}, 64'(dact_q.size()), 64'(dexp_q.size()));
    while (dact_q.size() > 0 && dexp_q.size() > 0) begin
      da = dact_q.pop_front();
      de = dexp_q.pop_front();
      n_chk++;
      if (da !== de) begin
        n_fail++;
        $display("FAIL %s_done: got cyc=%0d done=%b required cyc=%0d done=%b",
                 tag, da[35:4], da[3:0], de[35:4], de[3:0]);
      end
    end
    act_q.delete(); exp_q.delete(); dact_q.delete(); dexp_q.delete();
  endtask

  // ---------------- reference model data ----------------
  logic [7:0] idx_tab[NREG] = '{8'h00, 8'h01, 8'h02, 8'h03};
  int         aw_tab[NREG]  = '{13, 11, 13, 16};
  logic       m_err = 1'b0;

  function automatic int region_of(input logic [7:0] idx);
    for (int i = 0; i < NREG; i++) if (idx_tab[i] == idx) return i;
    return -1;
  endfunction

  logic [24:0] addr_q[$];
  logic [7:0]  data_q[$];

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One complete download of addr_q/data_q. rst_at aborts with reset at that byte;
  // ovl raises a second download (index 0) plus two writes during the fill.
  task automatic run_dl(input string tag, input logic [7:0] idx, input bit coincide,
                        input int gap_max, input int rst_at, input bit ovl);
    int r, sz, hwm, nfill, last;
    logic [3:0]  oh;
    logic [31:0] d, done_cyc, end_cyc;
    r    = region_of(idx);
    sz   = (r >= 0) ? (1 << aw_tab[r]) : 0;
    oh   = (r >= 0) ? 4'(1 << r) : 4'b0;
    hwm  = 0;
    last = addr_q.size() - 1;
    d    = '0;
    ioctl_index = idx; ioctl_download = 1'b1; ioctl_wr = 1'b0;
    tick();
    chk({tag, "_hold_rise"}, 64'(cpu_hold), 64'(1));
    if (r >= 0) m_err = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (r < 0) chk({tag, "_skip_hold"}, 64'(cpu_hold), 64'(1));
      ioctl_wr = 1'b1; ioctl_addr = addr_q[k]; ioctl_dout = data_q[k];
      if (k == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
        chk({tag, "_rst_outs"}, 64'({mem_we, mem_addr, mem_din, done, cpu_hold, busy, err}), 64'(0));
        m_err = 1'b0;
        tick();
        check_sb(tag);
        addr_q.delete(); data_q.delete();
        return;
      end
      if (coincide && k == last) ioctl_download = 1'b0;
      if (r >= 0) begin
        if (int'(addr_q[k]) < sz) begin
          exp_q.push_back({cyc + 32'd1, oh, addr_q[k][15:0], data_q[k]});
          if (int'(addr_q[k]) + 1 > hwm) hwm = int'(addr_q[k]) + 1;
        end else begin
          m_err = 1'b1;
        end
      end
      d = cyc;
      tick();
      ioctl_wr = 1'b0;
      if (k != last) repeat ($urandom_range(gap_max, 0)) tick();
    end
    if (!coincide) begin
      d = cyc;
      ioctl_download = 1'b0;
      tick();
    end
    if (r >= 0) begin
      if (FILL_EN[r] && hwm < sz) begin
        nfill = sz - hwm;
        for (int j = 0; j < nfill; j++)
          exp_q.push_back({d + 32'd2 + 32'(j), oh, 16'(hwm + j), FILL_BYTE});
        done_cyc = d + 32'd1 + 32'(nfill);
      end else begin
        done_cyc = d + 32'd1;
      end
      dexp_q.push_back({done_cyc, oh});
      while (cyc < done_cyc) begin
        if (ovl && cyc == d + 32'd10) begin ioctl_download = 1'b1; ioctl_index = 8'h00; end
        if (ovl && cyc == d + 32'd20) begin ioctl_wr = 1'b1; ioctl_addr = 25'h10; m_err = 1'b1; end
        if (ovl && cyc == d + 32'd22) ioctl_wr = 1'b0;
        tick();
      end
      chk({tag, "_hold_done"}, 64'(cpu_hold), 64'(1));
      chk({tag, "_err_done"}, 64'(err), 64'(m_err));
      end_cyc = done_cyc + 32'd1;
    end else begin
      end_cyc = d + 32'd1;
    end
    while (cyc < end_cyc) tick();
    chk({tag, "_hold_fall"}, 64'(cpu_hold), 64'(0));
    chk({tag, "_busy_fall"}, 64'(busy), 64'(0));
    chk({tag, "_err_end"}, 64'(err), 64'(m_err));
    check_sb(tag);
    addr_q.delete(); data_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  idx;
    int          n;
    int          base;
    int          bad_at;
    logic [24:0] bad_addr;
    bit          coincide;
    logic        exp_err;
    logic [3:0]  exp_done;
    int          exp_nwe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] d2;
    int r, sz, n, sel;
    logic [7:0] ridx;
    logic [7:0] pick[6];

    vecs[0] = '{8'h00, 4096, 'h0,    -1, 25'h0,       1'b0, 1'b0, 4'b0001, 4096};
    vecs[1] = '{8'h01, 1000, 'h0,    -1, 25'h0,       1'b0, 1'b0, 4'b0010, 2048};
    vecs[2] = '{8'h00, 20,   'h100,  10, 25'h2000,    1'b1, 1'b1, 4'b0001, 19};
    vecs[3] = '{8'h7F, 16,   'h0,    -1, 25'h0,       1'b0, 1'b1, 4'b0000, 0};
    vecs[4] = '{8'h03, 300,  'hFF00, -1, 25'h0,       1'b0, 1'b1, 4'b1000, 256};
    vecs[5] = '{8'h02, 4,    'h1FFE, 3,  25'h1000000, 1'b0, 1'b1, 4'b0100, 2};
    vecs[6] = '{8'h01, 2048, 'h0,    -1, 25'h0,       1'b1, 1'b0, 4'b0010, 2048};
    vecs[7] = '{8'h01, 1,    'h7FF,  -1, 25'h0,       1'b0, 1'b0, 4'b0010, 1};
    vecs[8] = '{8'h01, 1,    'h7FE,  -1, 25'h0,       1'b0, 1'b0, 4'b0010, 2};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) tick();
    chk("reset_outs", 64'({mem_we, mem_addr, mem_din, done, cpu_hold, busy, err}), 64'(0));
    reset = 1'b0;
    tick();
    chk("idle_hold", 64'(cpu_hold), 64'(0));

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        addr_q.push_back((k == vecs[v].bad_at) ? vecs[v].bad_addr : 25'(vecs[v].base + k));
        data_q.push_back(8'(k));
      end
      run_dl($sformatf("vec%0d", v), vecs[v].idx, vecs[v].coincide, 0, -1, 1'b0);
      chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_done", v), 64'(last_done), 64'(vecs[v].exp_done));
      chk($sformatf("vec%0d_nwe", v), 64'(last_nwe), 64'(vecs[v].exp_nwe));
    end

    // Write coincident with the download rising edge is dropped.
    ioctl_index = 8'h02; ioctl_download = 1'b1; ioctl_wr = 1'b1;
    ioctl_addr = 25'h5; ioctl_dout = 8'h33;
    tick();
    ioctl_wr = 1'b0;
    chk("rise_wr_hold", 64'(cpu_hold), 64'(1));
    ioctl_download = 1'b0;
    dexp_q.push_back({cyc + 32'd1, 4'b0100});
    tick(); tick();
    chk("rise_wr_err", 64'(err), 64'(0));
    check_sb("rise_wr");

    // Reset at byte 100 of a fill-enabled download, then a normal download.
    for (int k = 0; k < 150; k++) begin addr_q.push_back(25'(k)); data_q.push_back(8'(k ^ 8'h5A)); end
    run_dl("rst", 8'h01, 1'b0, 0, 100, 1'b0);
    for (int k = 0; k < 10; k++) begin addr_q.push_back(25'(k)); data_q.push_back(8'(k + 1)); end
    run_dl("after_rst", 8'h01, 1'b0, 0, -1, 1'b0);
    chk("after_rst_done", 64'(last_done), 64'(4'b0010));

    // Second download rises during the fill of the first.
    for (int k = 0; k < 100; k++) begin addr_q.push_back(25'(k)); data_q.push_back(8'(k)); end
    run_dl("ovl", 8'h01, 1'b0, 0, -1, 1'b1);
    tick();
    chk("ovl_load_hold", 64'(cpu_hold), 64'(1));
    chk("ovl_err_clear", 64'(err), 64'(0));
    ioctl_download = 1'b0;
    d2 = cyc;
    dexp_q.push_back({d2 + 32'd1, 4'b0001});
    tick(); tick();
    chk("ovl2_hold_fall", 64'(cpu_hold), 64'(0));
    check_sb("ovl2");
    m_err = 1'b0;

    // Random downloads.
    pick = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h55};
    for (int t = 0; t < 12; t++) begin
      ridx = pick[$urandom_range(5, 0)];
      r    = region_of(ridx);
      sz   = 1 << ((r >= 0) ? aw_tab[r] : 13);
      n    = $urandom_range(32, 1);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(9, 0);
        if (sel < 7)       addr_q.push_back(25'($urandom_range(sz - 1, 0)));
        else if (sel == 7) addr_q.push_back(25'(sz + $urandom_range(15, 0)));
        else if (sel == 8) addr_q.push_back(25'h1000000 | 25'($urandom_range(255, 0)));
        else               addr_q.push_back(25'(sz - 1));
        data_q.push_back(8'($urandom_range(255, 0)));
      end
      run_dl($sformatf("rnd%0d", t), ridx, 1'($urandom_range(1, 0)), 2, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
